// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register file's single write port between NUM_REQ
//            writeback requesters. Arbitration is round-robin and uses
//            valid/ready handshakes. The granted write is registered and
//            appears on the write port one cycle later. A per-register
//            pending scoreboard is set by decode claims and cleared by
//            committed writes. Decode uses it to detect RAW hazards on
//            rs1/rs2.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  register data width
//   NUM_REQ     number of writeback requesters (2..8), index 0 is lowest
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready/addr/data  requester handshakes, packed per index
//   wb_hold                    suppresses any grant this cycle
//   wr_en/rw_addr/wr_data      registered register-file write port
//   claim_valid/claim_addr     decode reservation of a destination register
//   rs1_addr/rs2_addr          decode source registers
//   rs1_busy/rs2_busy          source has an outstanding write
//   rsN_fwd_vld/rsN_fwd        same-cycle forward of the committing write
// Configuration
//   REGFILE_WB_BYPASS_EN       when defined, forwards the committing write to
//                              rs1/rs2 and masks their busy flags
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [5*NUM_REQ-1:0]          req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    input  logic                          wb_hold,
    output logic                          wr_en,
    output logic [4:0]                    rw_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          claim_valid,
    input  logic [4:0]                    claim_addr,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rs1_fwd_vld,
    output logic                          rs2_fwd_vld,
    output logic [DATA_WIDTH-1:0]         rs1_fwd,
    output logic [DATA_WIDTH-1:0]         rs2_fwd
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic                  r_wr_en;
    logic [4:0]            r_rw_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [31:0]           r_pend;

    logic [NUM_REQ-1:0]    w_hi_mask;
    logic [NUM_REQ-1:0]    w_hi_valid;
    logic [NUM_REQ-1:0]    w_pool;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_grant_any;
    logic [c_PTR_W-1:0]    w_ptr_next;
    logic [4:0]            w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [31:0]           w_pend_next;

    // ------------------------------------------------------------------
    // Round-robin arbitration. Requesters at or above the pointer are
    // searched first (lowest index wins); if none is valid the search
    // wraps to the full set. Grants are suppressed by hold and by reset
    // so a handshake can never complete in a reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_hi_mask   = '0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_ptr_next  = r_rr_ptr;
        w_sel_addr  = '0;
        w_sel_data  = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi_mask[i] = (i >= int'(r_rr_ptr));
        end
        w_hi_valid = req_valid & w_hi_mask;
        w_pool     = (|w_hi_valid) ? w_hi_valid : req_valid;

        if (rst_n && !wb_hold) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_grant_any && w_pool[i]) begin
                    w_grant_any = 1'b1;
                    w_grant[i]  = 1'b1;
                    w_sel_addr  = req_addr[i*5 +: 5];
                    w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    w_ptr_next  = (i == NUM_REQ - 1) ? '0 : c_PTR_W'(i + 1);
                end
            end
        end
    end

    assign req_ready = w_grant;

    // ------------------------------------------------------------------
    // Scoreboard update: the committing write clears its bit first, then
    // a claim sets its bit, so a same-cycle reclaim stays outstanding.
    // x0 is never pending.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pend;
        if (r_wr_en) begin
            w_pend_next[r_rw_addr] = 1'b0;
        end
        if (claim_valid && (claim_addr != 5'd0)) begin
            w_pend_next[claim_addr] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= 1'b0;
            r_rw_addr <= '0;
            r_wr_data <= '0;
            r_pend    <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_grant_any) begin
                r_rr_ptr  <= w_ptr_next;
                // A grant to x0 completes the handshake but never writes.
                r_wr_en   <= (w_sel_addr != 5'd0);
                r_rw_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign rw_addr = r_rw_addr;
    assign wr_data = r_wr_data;

    // ------------------------------------------------------------------
    // Hazard reporting. pend[0] is held at zero, so x0 is never busy.
    // ------------------------------------------------------------------
`ifdef REGFILE_WB_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rs1_reclaim;
    logic w_rs2_reclaim;

    assign w_rs1_hit     = r_wr_en && (r_rw_addr == rs1_addr) && (rs1_addr != 5'd0);
    assign w_rs2_hit     = r_wr_en && (r_rw_addr == rs2_addr) && (rs2_addr != 5'd0);
    assign w_rs1_reclaim = claim_valid && (claim_addr == rs1_addr);
    assign w_rs2_reclaim = claim_valid && (claim_addr == rs2_addr);

    // The committing value satisfies the hazard unless decode is already
    // reserving the same register again for a younger instruction.
    assign rs1_busy    = r_pend[rs1_addr] && !(w_rs1_hit && !w_rs1_reclaim);
    assign rs2_busy    = r_pend[rs2_addr] && !(w_rs2_hit && !w_rs2_reclaim);
    assign rs1_fwd_vld = w_rs1_hit;
    assign rs2_fwd_vld = w_rs2_hit;
    assign rs1_fwd     = w_rs1_hit ? r_wr_data : '0;
    assign rs2_fwd     = w_rs2_hit ? r_wr_data : '0;
`else
    assign rs1_busy    = r_pend[rs1_addr];
    assign rs2_busy    = r_pend[rs2_addr];
    assign rs1_fwd_vld = 1'b0;
    assign rs2_fwd_vld = 1'b0;
    assign rs1_fwd     = '0;
    assign rs2_fwd     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter: a directed vector
//            table, hand-written multi-cycle sequences and a randomized run
//            compared against a behavioural model of the write port,
//            round-robin pointer and pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_addr;
    logic [DW*N-1:0] req_data;
    logic            wb_hold;
    logic            wr_en;
    logic [4:0]      rw_addr;
    logic [DW-1:0]   wr_data;
    logic            claim_valid;
    logic [4:0]      claim_addr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rs1_fwd_vld;
    logic            rs2_fwd_vld;
    logic [DW-1:0]   rs1_fwd;
    logic [DW-1:0]   rs2_fwd;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wb_hold(wb_hold),
        .wr_en(wr_en), .rw_addr(rw_addr), .wr_data(wr_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd_vld(rs1_fwd_vld), .rs2_fwd_vld(rs2_fwd_vld),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit            m_known = 1'b0;
    int            m_ptr   = 0;
    bit            m_wr_en = 1'b0;
    bit [4:0]      m_rw_addr;
    bit [DW-1:0]   m_wr_data;
    bit [31:0]     m_pend;
    bit [N-1:0]    m_last_grant;

    // Index of the requester that should be granted now, or -1.
    function automatic int pick();
        if (rst_n !== 1'b1 || wb_hold) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = pick();
        m_last_grant = '0;
        if (!rst_n) begin
            m_ptr = 0; m_wr_en = 0; m_rw_addr = 0; m_wr_data = 0; m_pend = 0;
            m_known = 1'b1;
        end else begin
            if (m_wr_en) m_pend[m_rw_addr] = 1'b0;
            if (claim_valid && claim_addr != 5'd0) m_pend[claim_addr] = 1'b1;
            m_wr_en = 1'b0;
            if (g >= 0) begin
                m_last_grant[g] = 1'b1;
                m_ptr     = (g + 1) % N;
                m_rw_addr = req_addr[g*5 +: 5];
                m_wr_data = req_data[g*DW +: DW];
                m_wr_en   = (m_rw_addr != 5'd0);
            end
        end
    end

    task automatic check_src(input string nm, input logic [4:0] a, input logic busy,
                             input logic vld, input logic [DW-1:0] fwd);
        bit hit;
        bit eb;
        hit = m_wr_en && (m_rw_addr == a) && (a != 5'd0);
        eb  = m_pend[a];
`ifdef REGFILE_WB_BYPASS_EN
        if (hit && !(claim_valid && claim_addr == a)) eb = 1'b0;
        chk({nm, "_fwd_vld"}, 64'(vld), 64'(hit));
        if (hit) chk({nm, "_fwd"}, 64'(fwd), 64'(m_wr_data));
`else
        chk({nm, "_fwd_vld"}, 64'(vld), 64'(0));
        chk({nm, "_fwd"}, 64'(fwd), 64'(0));
`endif
        chk({nm, "_busy"}, 64'(busy), 64'(eb));
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            int g;
            bit [N-1:0] er;
            g  = pick();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("model_req_ready", 64'(req_ready), 64'(er));
            chk("model_wr_en", 64'(wr_en), 64'(m_wr_en));
            if (m_wr_en) begin
                chk("model_rw_addr", 64'(rw_addr), 64'(m_rw_addr));
                chk("model_wr_data", 64'(wr_data), 64'(m_wr_data));
            end
            check_src("model_rs1", rs1_addr, rs1_busy, rs1_fwd_vld, rs1_fwd);
            check_src("model_rs2", rs2_addr, rs2_busy, rs2_fwd_vld, rs2_fwd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        bit [N-1:0] valid;
        bit         hold;
        bit [N-1:0] exp_ready;
        bit         exp_wr_en;
        bit [4:0]   exp_rw_addr;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit [N-1:0] v, input bit [4:0] a0, input bit [4:0] a1,
                           input bit [4:0] a2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    endtask

    task automatic randomize_all();
        req_valid   = N'($urandom_range(0, 7));
        req_addr    = 15'($urandom);
        req_data    = {$urandom, $urandom, $urandom};
        wb_hold     = 1'($urandom_range(0, 1));
        claim_valid = 1'($urandom_range(0, 1));
        claim_addr  = 5'($urandom);
        rs1_addr    = 5'($urandom);
        rs2_addr    = 5'($urandom);
    endtask

    initial begin
        // Grants rotate 0,1,2 with all valid; hold blocks and keeps pointer.
        tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 5'd0};
        tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd5};
        tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd6};
        tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd7};
        tbl[4]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd5};
        tbl[5]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd6};
        tbl[6]  = '{3'b010, 1'b1, 3'b000, 1'b1, 5'd7};
        tbl[7]  = '{3'b010, 1'b0, 3'b010, 1'b0, 5'd7};
        tbl[8]  = '{3'b101, 1'b0, 3'b100, 1'b1, 5'd6};
        tbl[9]  = '{3'b101, 1'b0, 3'b001, 1'b1, 5'd7};
        tbl[10] = '{3'b000, 1'b0, 3'b000, 1'b1, 5'd5};
        tbl[11] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd5};

        // Reset for two cycles with random inputs.
        rst_n = 1'b0;
        randomize_all();
        tick();
        randomize_all();
        @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_rw_addr", 64'(rw_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rs1_busy", 64'(rs1_busy), 64'(0));
        chk("rst_rs2_busy", 64'(rs2_busy), 64'(0));
        tick();
        rst_n = 1'b1; wb_hold = 1'b0; claim_valid = 1'b0; claim_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;

        // Table-driven rotation / hold vectors.
        for (int r = 0; r < 12; r++) begin
            set_req(tbl[r].valid, 5'd5, 5'd6, 5'd7);
            wb_hold = tbl[r].hold;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            chk($sformatf("tbl%0d_wr_en", r), 64'(wr_en), 64'(tbl[r].exp_wr_en));
            chk($sformatf("tbl%0d_rw_addr", r), 64'(rw_addr), 64'(tbl[r].exp_rw_addr));
            tick();
        end

        // Claim x9, then requester 1 writes 0xDEADBEEF to x9.
        set_req(3'b000, 5'd0, 5'd0, 5'd0);
        claim_valid = 1'b1; claim_addr = 5'd9;
        tick();
        claim_valid = 1'b0; rs1_addr = 5'd9;
        set_req(3'b010, 5'd0, 5'd9, 5'd0);
        req_data[DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("x9_busy_before", 64'(rs1_busy), 64'(1));
        chk("x9_ready", 64'(req_ready), 64'(3'b010));
        tick();
        set_req(3'b000, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("x9_commit_wr_en", 64'(wr_en), 64'(1));
        chk("x9_commit_addr", 64'(rw_addr), 64'(9));
        chk("x9_commit_data", 64'(wr_data), 64'(32'hDEAD_BEEF));
`ifdef REGFILE_WB_BYPASS_EN
        chk("x9_commit_busy", 64'(rs1_busy), 64'(0));
        chk("x9_fwd_vld", 64'(rs1_fwd_vld), 64'(1));
        chk("x9_fwd", 64'(rs1_fwd), 64'(32'hDEAD_BEEF));
`else
        chk("x9_commit_busy", 64'(rs1_busy), 64'(1));
        chk("x9_fwd_vld", 64'(rs1_fwd_vld), 64'(0));
`endif
        tick();
        @(negedge clk);
        chk("x9_busy_after", 64'(rs1_busy), 64'(0));
        chk("x9_wr_en_after", 64'(wr_en), 64'(0));
        tick();

        // Write to x0 completes the handshake, advances the pointer, no write.
        set_req(3'b001, 5'd0, 5'd6, 5'd7);
        req_data[0 +: DW] = 32'h0000_1234;
        claim_valid = 1'b1; claim_addr = 5'd0; rs1_addr = 5'd0;
        @(negedge clk);
        chk("x0_ready", 64'(req_ready), 64'(3'b001));
        tick();
        claim_valid = 1'b0;
        set_req(3'b011, 5'd5, 5'd6, 5'd7);
        @(negedge clk);
        chk("x0_wr_en", 64'(wr_en), 64'(0));
        chk("x0_busy", 64'(rs1_busy), 64'(0));
        chk("x0_ptr_advanced", 64'(req_ready), 64'(3'b010));
        tick();
        set_req(3'b000, 5'd0, 5'd0, 5'd0);
        tick();

        // Commit of x4 coincides with a new claim of x4: stays pending.
        claim_valid = 1'b1; claim_addr = 5'd4;
        tick();
        claim_valid = 1'b0;
        set_req(3'b100, 5'd0, 5'd0, 5'd4);
        @(negedge clk);
        chk("x4_ready", 64'(req_ready), 64'(3'b100));
        tick();
        set_req(3'b000, 5'd0, 5'd0, 5'd0);
        claim_valid = 1'b1; claim_addr = 5'd4; rs1_addr = 5'd4;
        @(negedge clk);
        chk("x4_commit_wr_en", 64'(wr_en), 64'(1));
        chk("x4_commit_addr", 64'(rw_addr), 64'(4));
        chk("x4_commit_busy", 64'(rs1_busy), 64'(1));
        tick();
        claim_valid = 1'b0;
        @(negedge clk);
        chk("x4_busy_after", 64'(rs1_busy), 64'(1));
        tick();

        // Hold blocks grant and keeps pointer at 0.
        wb_hold = 1'b1;
        set_req(3'b010, 5'd5, 5'd6, 5'd7);
        @(negedge clk);
        chk("hold_ready", 64'(req_ready), 64'(0));
        tick();
        wb_hold = 1'b0;
        set_req(3'b011, 5'd5, 5'd6, 5'd7);
        @(negedge clk);
        chk("release_ready", 64'(req_ready), 64'(3'b001));
        tick();

        // Reset in the cycle after a grant: write and pending bits discarded.
        set_req(3'b010, 5'd5, 5'd6, 5'd7);
        claim_valid = 1'b1; claim_addr = 5'd3;
        @(negedge clk);
        chk("pre_rst_ready", 64'(req_ready), 64'(3'b010));
        tick();
        rst_n = 1'b0; claim_valid = 1'b0;
        set_req(3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        rst_n = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4;
        @(negedge clk);
        chk("post_rst_wr_en", 64'(wr_en), 64'(0));
        chk("post_rst_rw_addr", 64'(rw_addr), 64'(0));
        chk("post_rst_rs1_busy", 64'(rs1_busy), 64'(0));
        chk("post_rst_rs2_busy", 64'(rs2_busy), 64'(0));
        tick();

        // Randomized run against the model; requesters hold until granted.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !m_last_grant[i])) begin
                    req_valid[i]         = 1'($urandom_range(0, 1));
                    req_addr[i*5 +: 5]   = 5'($urandom_range(0, 12));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            wb_hold     = ($urandom_range(0, 7) == 0);
            claim_valid = 1'($urandom_range(0, 1));
            claim_addr  = 5'($urandom_range(0, 12));
            rs1_addr    = 5'($urandom_range(0, 12));
            rs2_addr    = 5'($urandom_range(0, 12));
            rst_n       = ($urandom_range(0, 99) != 0);
            tick();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
